// File: rtl/acc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc4_pkg
// Purpose  : Shared types and helpers for the 4-bit accumulator sequencer.
//            Operation and FSM-state encodings, datapath width, and the
//            negative/zero flag helper used at write-back.
// Revision : 1.0 - initial release
// ============================================================================
package acc4_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    SUB  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns {negative, zero} for a freshly written accumulator value.
  function automatic logic [1:0] nz_flags(input logic [W-1:0] value);
    return {value[W-1], (value == '0)};
  endfunction

endpackage : acc4_pkg
`default_nettype wire

// File: rtl/acc4_seq.sv
`default_nettype none
// ============================================================================
// Module   : acc4_seq
// Purpose  : 4-bit accumulator sequencer wrapped around an external addsub4.
//            Accepts CLR/LOAD/ADD/SUB requests over valid/ready, drives the
//            adder from registered state only, writes back the result and
//            flags, and presents them over a second valid/ready handshake.
// Ports    :
//   clk, resetn              clock; async-assert active-low reset
//   in_valid/in_ready        request handshake
//   in_op[1:0], in_data[3:0] operation code and operand
//   as_a, as_b, as_sub       to addsub4 (A, B, sub)
//   as_s, as_c, as_v         from addsub4 (sum, carry/borrow, overflow)
//   acc[3:0]                 accumulator
//   flag_n/z/c/v             flags of the last operation
//   ovf_sticky               accumulated overflow, cleared by CLR or reset
//   out_valid/out_ready      result handshake
// Revision : 1.0 - initial release
// ============================================================================
module acc4_seq
  import acc4_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] as_a,
  output logic [W-1:0] as_b,
  output logic         as_sub,
  input  logic [W-1:0] as_s,
  input  logic         as_c,
  input  logic         as_v,
  output logic [W-1:0] acc,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         ovf_sticky,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       r_state;
  op_t          r_op;
  logic [W-1:0] r_opnd;
  logic [W-1:0] r_acc;
  logic         r_flag_n;
  logic         r_flag_z;
  logic         r_flag_c;
  logic         r_flag_v;
  logic         r_ovf_sticky;

  logic [W-1:0] w_acc_next;
  logic         w_c_next;
  logic         w_v_next;
  logic         w_ovf_next;
  logic [1:0]   w_nz_next;

  // Write-back values; only consumed on the EXEC -> RESP edge. The adder
  // outputs are ignored for CLR/LOAD.
  always_comb begin
    w_acc_next = r_acc;
    w_c_next   = 1'b0;
    w_v_next   = 1'b0;
    w_ovf_next = r_ovf_sticky;
    case (r_op)
      CLR: begin
        w_acc_next = '0;
        w_ovf_next = 1'b0;
      end
      LOAD: begin
        w_acc_next = r_opnd;
      end
      ADD, SUB: begin
        w_acc_next = as_s;
        w_c_next   = as_c;
        w_v_next   = as_v;
        w_ovf_next = r_ovf_sticky | as_v;
      end
      default: begin
        w_acc_next = r_acc;
      end
    endcase
    w_nz_next = nz_flags(w_acc_next);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_op         <= CLR;
      r_opnd       <= '0;
      r_acc        <= '0;
      r_flag_n     <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_c     <= 1'b0;
      r_flag_v     <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= op_t'(in_op);
            r_opnd  <= in_data;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_acc        <= w_acc_next;
          r_flag_n     <= w_nz_next[1];
          r_flag_z     <= w_nz_next[0];
          r_flag_c     <= w_c_next;
          r_flag_v     <= w_v_next;
          r_ovf_sticky <= w_ovf_next;
          r_state      <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Everything below decodes registered state only, so the addsub4 path
  // stays register-to-register with no combinational path from in_*.
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == RESP);
  assign as_a       = r_acc;
  assign as_b       = r_opnd;
  assign as_sub     = (r_op == SUB);
  assign acc        = r_acc;
  assign flag_n     = r_flag_n;
  assign flag_z     = r_flag_z;
  assign flag_c     = r_flag_c;
  assign flag_v     = r_flag_v;
  assign ovf_sticky = r_ovf_sticky;

endmodule : acc4_seq
`default_nettype wire

// File: tb/tb_acc4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc4_seq
// Purpose  : Self-checking bench for acc4_seq. Plays the parent: provides an
//            addsub4 stand-in, drives requests, and compares the DUT against
//            an arithmetic reference model of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc4_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic [3:0] as_a;
  logic [3:0] as_b;
  logic       as_sub;
  logic [3:0] as_s;
  logic       as_c;
  logic       as_v;
  logic [3:0] acc;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       ovf_sticky;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_acc, m_n, m_z, m_c, m_v, m_ovf;

  always #5 clk = ~clk;

  acc4_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .as_a       (as_a),
    .as_b       (as_b),
    .as_sub     (as_sub),
    .as_s       (as_s),
    .as_c       (as_c),
    .as_v       (as_v),
    .acc        (acc),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .ovf_sticky (ovf_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // addsub4 stand-in: two's-complement add of A and (optionally inverted) B.
  logic [4:0] w_sum;
  logic [3:0] w_bb;
  always_comb begin
    w_bb  = as_sub ? ~as_b : as_b;
    w_sum = {1'b0, as_a} + {1'b0, w_bb} + {4'b0, as_sub};
    as_s  = w_sum[3:0];
    as_c  = as_sub ? ~w_sum[4] : w_sum[4];
    as_v  = (as_a[3] == w_bb[3]) && (w_sum[3] != as_a[3]);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic int model_flags();
    return (m_n << 3) | (m_z << 2) | (m_c << 1) | m_v;
  endfunction

  function automatic int dut_flags();
    return {28'b0, flag_n, flag_z, flag_c, flag_v};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ovf = 0;
  endtask

  // Reference: plain integer arithmetic on the specification's rules.
  task automatic model_apply(input int op, input int d);
    int sv;
    case (op)
      0: begin m_acc = 0; m_c = 0; m_v = 0; m_ovf = 0; end
      1: begin m_acc = d; m_c = 0; m_v = 0; end
      2: begin
        sv    = to_signed4(m_acc) + to_signed4(d);
        m_c   = (m_acc + d > 15) ? 1 : 0;
        m_v   = (sv > 7 || sv < -8) ? 1 : 0;
        m_acc = (m_acc + d) % 16;
        m_ovf = m_ovf | m_v;
      end
      default: begin
        sv    = to_signed4(m_acc) - to_signed4(d);
        m_c   = (m_acc < d) ? 1 : 0;
        m_v   = (sv > 7 || sv < -8) ? 1 : 0;
        m_acc = (m_acc - d + 16) % 16;
        m_ovf = m_ovf | m_v;
      end
    endcase
    m_n = (m_acc >= 8) ? 1 : 0;
    m_z = (m_acc == 0) ? 1 : 0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_acc"},   acc, m_acc);
    check({tag, "_flags"}, dut_flags(), model_flags());
    check({tag, "_ovf"},   ovf_sticky, m_ovf);
  endtask

  // One full transaction; bp = cycles of back-pressure in RESP.
  task automatic do_op(input int op, input int d, input int bp, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = op[1:0]; in_data = d[3:0]; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_exec_valid"}, out_valid, 0);
    check({tag, "_as_a"},   as_a, m_acc);
    check({tag, "_as_b"},   as_b, d);
    check({tag, "_as_sub"}, as_sub, (op == 3) ? 1 : 0);
    model_apply(op, d);
    @(negedge clk);
    check_result(tag);
    check({tag, "_resp_ready"}, in_ready, 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_result({tag, "_bp"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_data = 4'd0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_acc", acc, 0);
    check("rst_flags", dut_flags(), 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_as", {as_a, as_b, as_sub}, 0);
    resetn = 1'b1;

    // Directed cases.
    do_op(1, 3, 0, "ld3");
    do_op(3, 5, 0, "sub5");      // acc=E, N=1, C=1
    do_op(1, 7, 0, "ld7");
    do_op(2, 1, 1, "add1_ovf");  // acc=8, V=1, sticky
    do_op(2, 1, 0, "add1_more"); // acc=9, V=0, sticky holds
    do_op(1, 15, 0, "ld15");
    do_op(2, 1, 0, "add_wrap");  // acc=0, Z=1, C=1
    do_op(1, 8, 0, "ld8");
    do_op(3, 1, 0, "sub_ovf");   // acc=7, V=1, C=0
    do_op(0, 9, 0, "clr");       // clears sticky

    // Back-pressure with a new request held at the input throughout.
    do_op(1, 4, 0, "bp_ld");
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd2; in_data = 4'd2;
    @(negedge clk);
    in_op = 2'd2; in_data = 4'd3;
    @(negedge clk);
    model_apply(2, 2);
    for (int i = 0; i < 5; i++) begin
      check_result("bp_hold");
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    check_result("bp_hold_end");
    out_ready = 1'b1;
    @(negedge clk);            // back to IDLE, held request visible
    out_ready = 1'b0;
    check("bp_release_idle", out_valid, 0);
    @(negedge clk);            // accepted, now EXEC
    in_valid = 1'b0;
    check("bp_second_as_b", as_b, 3);
    model_apply(2, 3);
    @(negedge clk);            // third cycle after release: result
    check_result("bp_second");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      do_op(int'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 3)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), "rnd");
    end

    // Asynchronous reset while holding a result in RESP.
    do_op(1, 7, 0, "pre_rst_ld");
    do_op(2, 1, 0, "pre_rst_add");
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd3; in_data = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_resp", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("arst_acc", acc, 0);
    check("arst_flags", dut_flags(), 0);
    check("arst_ovf", ovf_sticky, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_as", {as_a, as_b, as_sub}, 0);
    @(negedge clk);
    resetn = 1'b1;
    do_op(2, 6, 0, "post_rst_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_acc4_seq
`default_nettype wire
